// File: rtl/control32_mc_if.sv
// Control bus between control32_mc and the IR/ifetch unit and datapath.
// master: the control unit (drives strobes, samples decode inputs).
// slave:  the datapath side (drives IR fields, ALU flags and Mem_ready).
interface control32_mc_if #(
   parameter int IO_BITS   = 22,
   parameter int CNT_WIDTH = 32
);
   logic [5:0]           Opcode;
   logic [5:0]           Function_opcode;
   logic [IO_BITS-1:0]   Alu_resultHigh;
   logic                 Zero;
   logic                 Mem_ready;

   logic [2:0]           State;
   logic                 IRWrite;
   logic                 PCWrite;
   logic                 PCSrc;
   logic                 RegDST;
   logic                 ALUSrc;
   logic                 MemorIOtoReg;
   logic                 Jmp;
   logic                 Jal;
   logic                 Jrn;
   logic                 I_format;
   logic                 Sftmd;
   logic [1:0]           ALUOp;
   logic                 RegWrite;
   logic                 MemRead;
   logic                 MemWrite;
   logic                 IORead;
   logic                 IOWrite;
   logic                 Illegal;
   logic [CNT_WIDTH-1:0] Retired;

   modport master (
      input  Opcode, Function_opcode, Alu_resultHigh, Zero, Mem_ready,
      output State, IRWrite, PCWrite, PCSrc, RegDST, ALUSrc, MemorIOtoReg,
             Jmp, Jal, Jrn, I_format, Sftmd, ALUOp, RegWrite, MemRead,
             MemWrite, IORead, IOWrite, Illegal, Retired
   );

   modport slave (
      output Opcode, Function_opcode, Alu_resultHigh, Zero, Mem_ready,
      input  State, IRWrite, PCWrite, PCSrc, RegDST, ALUSrc, MemorIOtoReg,
             Jmp, Jal, Jrn, I_format, Sftmd, ALUOp, RegWrite, MemRead,
             MemWrite, IORead, IOWrite, Illegal, Retired
   );
endinterface

// File: rtl/control32_mc.sv
// Multi-cycle MIPS-subset control unit: level decode plus an
// IF/ID/EX/MEM/WB sequencer with a ready-stalled memory/IO phase and a
// retired-instruction counter.
module control32_mc #(
   parameter int                 IO_BITS   = 22,
   parameter logic [IO_BITS-1:0] IO_BASE   = {IO_BITS{1'b1}},
   parameter int                 CNT_WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset,
   control32_mc_if.master bus
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] retired;

   logic r_format, i_format, lw, sw, beq, bne, jmp, jal, jrn;
   logic funct_ok, legal, io;
   logic ir_write, pc_write, pc_src, reg_write;
   logic mem_read, mem_write, io_read, io_write;
   logic illegal, retire;

   // Opcode class decode, same meaning as the single-cycle unit.
   always_comb begin
      r_format = (bus.Opcode == 6'b000000);
      i_format = (bus.Opcode[5:3] == 3'b001);
      lw       = (bus.Opcode == 6'b100011);
      sw       = (bus.Opcode == 6'b101011);
      beq      = (bus.Opcode == 6'b000100);
      bne      = (bus.Opcode == 6'b000101);
      jmp      = (bus.Opcode == 6'b000010);
      jal      = (bus.Opcode == 6'b000011);
      jrn      = r_format && (bus.Function_opcode == 6'b001000);
   end

   // Supported R-format function codes.
   always_comb begin
      funct_ok = 1'b0;
      case (bus.Function_opcode)
         6'b100000, 6'b100001, 6'b100010, 6'b100011,
         6'b100100, 6'b100101, 6'b100110, 6'b100111,
         6'b101010, 6'b101011,
         6'b000000, 6'b000010, 6'b000011,
         6'b000100, 6'b000110, 6'b000111,
         6'b001000: funct_ok = 1'b1;
         default:   funct_ok = 1'b0;
      endcase
   end

   assign legal = (r_format && funct_ok) || i_format || lw || sw ||
                  beq || bne || jmp || jal;

   // I/O space is selected purely by the high ALU-result bits.
   assign io = (bus.Alu_resultHigh == IO_BASE);

   // Level decode outputs: independent of state.
   assign bus.RegDST       = r_format;
   assign bus.ALUSrc       = i_format || lw || sw;
   assign bus.MemorIOtoReg = lw;
   assign bus.Jmp          = jmp;
   assign bus.Jal          = jal;
   assign bus.Jrn          = jrn;
   assign bus.I_format     = i_format;
   assign bus.Sftmd        = r_format && (bus.Function_opcode[5:3] == 3'b000);
   assign bus.ALUOp        = {r_format || i_format, beq || bne};

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IF;
      else       state <= state_nxt;
   end

   // Next-state and state-gated strobes.
   always_comb begin
      state_nxt = S_IF;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      io_read   = 1'b0;
      io_write  = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IF: begin
            ir_write  = 1'b1;
            state_nxt = S_ID;
         end
         S_ID: begin
            if (!legal) begin
               // Refetch from the same PC; nothing retires.
               illegal   = 1'b1;
               state_nxt = S_IF;
            end else begin
               state_nxt = S_EX;
            end
         end
         S_EX: begin
            if (beq || bne) begin
               pc_write  = 1'b1;
               pc_src    = (beq && bus.Zero) || (bne && !bus.Zero);
               retire    = 1'b1;
               state_nxt = S_IF;
            end else if (jmp || jrn) begin
               // Jmp/Jrn steer the target mux in the datapath.
               pc_write  = 1'b1;
               retire    = 1'b1;
               state_nxt = S_IF;
            end else if (lw || sw) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            // Strobe is held until the access completes; no timeout.
            if (lw) begin
               io_read  = io;
               mem_read = !io;
            end
            if (sw) begin
               io_write  = io;
               mem_write = !io;
            end
            if (!bus.Mem_ready) begin
               state_nxt = S_MEM;
            end else if (lw) begin
               state_nxt = S_WB;
            end else if (sw) begin
               pc_write  = 1'b1;
               retire    = 1'b1;
               state_nxt = S_IF;
            end else begin
               state_nxt = S_IF;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_nxt = S_IF;
         end
         default: state_nxt = S_IF;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_WIDTH.
   always_ff @(posedge clock) begin
      if (reset)       retired <= '0;
      else if (retire) retired <= retired + 1'b1;
   end

   // Side-effecting strobes are suppressed while reset is asserted so an
   // abandoned instruction cannot commit anything in the reset cycle.
   assign bus.State    = state;
   assign bus.IRWrite  = ir_write;
   assign bus.PCWrite  = pc_write  && !reset;
   assign bus.PCSrc    = pc_src;
   assign bus.RegWrite = reg_write && !reset;
   assign bus.MemRead  = mem_read  && !reset;
   assign bus.MemWrite = mem_write && !reset;
   assign bus.IORead   = io_read   && !reset;
   assign bus.IOWrite  = io_write  && !reset;
   assign bus.Illegal  = illegal;
   assign bus.Retired  = retired;

endmodule

// File: tb/tb_control32_mc.sv
// Directed table-driven bench for control32_mc, plus hand sequences for
// reset during a stalled MEM phase and counter wrap with a 4-bit counter.
module tb_control32_mc;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rst2  = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   control32_mc_if #(.IO_BITS(22), .CNT_WIDTH(32)) bus1 ();
   control32_mc_if #(.IO_BITS(22), .CNT_WIDTH(4))  bus2 ();

   control32_mc #(.IO_BITS(22), .CNT_WIDTH(32)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1));
   control32_mc #(.IO_BITS(22), .CNT_WIDTH(4))  dut2 (
      .clock(clock), .reset(rst2),  .bus(bus2));

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [21:0] hi;
      logic        zero;
      int          stall;
      logic        chk_dec;
      logic [9:0]  dec;    // {RegDST,ALUSrc,MemorIOtoReg,Jmp,Jal,Jrn,I_format,Sftmd,ALUOp}
      int          cyc;
      logic [29:0] trace;  // State per cycle, 3 bits each, oldest first
      int          rw, mr, mw, ior, iow, pcw;
      logic        pcsrc;
      int          ill;
      int          ret;
   } vec_t;

   localparam int NV = 17;
   vec_t tv [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   initial begin
      logic [29:0] trace;
      logic [31:0] ret0;
      logic        pcsrc_seen, done;
      int          cyc, stall, rw, mr, mw, ior, iow, pcw, ill, excl;

      //        name     op         fn         hi          z  st dc dec             cyc trace         rw mr mw ior iow pcw ps ill ret
      tv[0]  = '{"add",  6'b000000, 6'b100000, 22'h0,      0, 0, 1, 10'b1000000010, 4, 30'o0124,     1, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[1]  = '{"lw_io",6'b100011, 6'b000000, 22'h3FFFFF, 0, 3, 1, 10'b0110000000, 8, 30'o01233334, 1, 0, 0, 4, 0, 1, 0, 0, 1};
      tv[2]  = '{"sw_mem",6'b101011,6'b000000, 22'h0,      0, 0, 1, 10'b0100000000, 4, 30'o0123,     0, 0, 1, 0, 0, 1, 0, 0, 1};
      tv[3]  = '{"beq_z1",6'b000100,6'b000000, 22'h0,      1, 0, 1, 10'b0000000001, 3, 30'o012,      0, 0, 0, 0, 0, 1, 1, 0, 1};
      tv[4]  = '{"bne_z1",6'b000101,6'b000000, 22'h0,      1, 0, 1, 10'b0000000001, 3, 30'o012,      0, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[5]  = '{"ill_op",6'b111111,6'b000000, 22'h0,      0, 0, 1, 10'b0000000000, 2, 30'o01,       0, 0, 0, 0, 0, 0, 0, 1, 0};
      tv[6]  = '{"jr",   6'b000000, 6'b001000, 22'h0,      0, 0, 1, 10'b1000010010, 3, 30'o012,      0, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[7]  = '{"j",    6'b000010, 6'b000000, 22'h0,      0, 0, 1, 10'b0001000000, 3, 30'o012,      0, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[8]  = '{"jal",  6'b000011, 6'b000000, 22'h0,      0, 0, 1, 10'b0000100000, 4, 30'o0124,     1, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[9]  = '{"addi", 6'b001000, 6'b000000, 22'h0,      0, 0, 1, 10'b0100001010, 4, 30'o0124,     1, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[10] = '{"sll",  6'b000000, 6'b000000, 22'h0,      0, 0, 1, 10'b1000000110, 4, 30'o0124,     1, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[11] = '{"ill_fn",6'b000000,6'b000001, 22'h0,      0, 0, 0, 10'b0000000000, 2, 30'o01,       0, 0, 0, 0, 0, 0, 0, 1, 0};
      tv[12] = '{"lw_mem",6'b100011,6'b000000, 22'h0,      0, 0, 1, 10'b0110000000, 5, 30'o01234,    1, 1, 0, 0, 0, 1, 0, 0, 1};
      tv[13] = '{"sw_io",6'b101011, 6'b000000, 22'h3FFFFF, 0, 2, 1, 10'b0100000000, 6, 30'o012333,   0, 0, 0, 0, 3, 1, 0, 0, 1};
      tv[14] = '{"beq_z0",6'b000100,6'b000000, 22'h0,      0, 0, 1, 10'b0000000001, 3, 30'o012,      0, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[15] = '{"bne_z0",6'b000101,6'b000000, 22'h0,      0, 0, 1, 10'b0000000001, 3, 30'o012,      0, 0, 0, 0, 0, 1, 1, 0, 1};
      tv[16] = '{"ori",  6'b001101, 6'b000000, 22'h0,      0, 0, 1, 10'b0100001010, 4, 30'o0124,     1, 0, 0, 0, 0, 1, 0, 0, 1};

      bus1.Opcode = 6'b0; bus1.Function_opcode = 6'b0; bus1.Alu_resultHigh = '0;
      bus1.Zero = 1'b0; bus1.Mem_ready = 1'b0;
      bus2.Opcode = 6'b000010; bus2.Function_opcode = 6'b0; bus2.Alu_resultHigh = '0;
      bus2.Zero = 1'b0; bus2.Mem_ready = 1'b0;

      // Reset for two cycles.
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_state",   32'(bus1.State),    32'd0);
      chk("rst_irwrite", 32'(bus1.IRWrite),  32'd1);
      chk("rst_pcwrite", 32'(bus1.PCWrite),  32'd0);
      chk("rst_regwr",   32'(bus1.RegWrite), 32'd0);
      chk("rst_retired", bus1.Retired,       32'd0);

      // Table: each vector starts in IF and runs until State returns to IF.
      for (int k = 0; k < NV; k++) begin
         bus1.Opcode = tv[k].op;
         bus1.Function_opcode = tv[k].fn;
         bus1.Alu_resultHigh = tv[k].hi;
         bus1.Zero = tv[k].zero;
         bus1.Mem_ready = 1'b0;
         ret0 = bus1.Retired;
         trace = '0; pcsrc_seen = 1'b0; done = 1'b0;
         cyc = 0; stall = tv[k].stall;
         rw = 0; mr = 0; mw = 0; ior = 0; iow = 0; pcw = 0; ill = 0; excl = 0;
         #1;
         if (tv[k].chk_dec)
            chk({tv[k].name, "_dec"},
                32'({bus1.RegDST, bus1.ALUSrc, bus1.MemorIOtoReg, bus1.Jmp, bus1.Jal,
                     bus1.Jrn, bus1.I_format, bus1.Sftmd, bus1.ALUOp}), 32'(tv[k].dec));
         while (!done && cyc < 20) begin
            if (bus1.State == 3'd3) begin
               bus1.Mem_ready = (stall == 0);
               if (stall > 0) stall--;
            end else begin
               bus1.Mem_ready = 1'b0;
            end
            #1;
            trace = {trace[26:0], bus1.State};
            rw  += int'(bus1.RegWrite);
            mr  += int'(bus1.MemRead);
            mw  += int'(bus1.MemWrite);
            ior += int'(bus1.IORead);
            iow += int'(bus1.IOWrite);
            ill += int'(bus1.Illegal);
            if (bus1.PCWrite) begin
               pcw++;
               pcsrc_seen = bus1.PCSrc;
            end
            if ((int'(bus1.MemRead) + int'(bus1.MemWrite) + int'(bus1.IORead) +
                 int'(bus1.IOWrite)) > 1 || (bus1.PCWrite && bus1.IRWrite))
               excl++;
            @(posedge clock);
            #1;
            cyc++;
            if (bus1.State == 3'd0) done = 1'b1;
         end
         bus1.Mem_ready = 1'b0;
         chk({tv[k].name, "_done"},  32'(done),  32'd1);
         chk({tv[k].name, "_cyc"},   cyc,        tv[k].cyc);
         chk({tv[k].name, "_trace"}, 32'(trace), 32'(tv[k].trace));
         chk({tv[k].name, "_rw"},    rw,         tv[k].rw);
         chk({tv[k].name, "_mr"},    mr,         tv[k].mr);
         chk({tv[k].name, "_mw"},    mw,         tv[k].mw);
         chk({tv[k].name, "_ior"},   ior,        tv[k].ior);
         chk({tv[k].name, "_iow"},   iow,        tv[k].iow);
         chk({tv[k].name, "_pcw"},   pcw,        tv[k].pcw);
         chk({tv[k].name, "_pcsrc"}, 32'(pcsrc_seen), 32'(tv[k].pcsrc));
         chk({tv[k].name, "_ill"},   ill,        tv[k].ill);
         chk({tv[k].name, "_excl"},  excl,       0);
         chk({tv[k].name, "_ret"},   bus1.Retired - ret0, 32'(tv[k].ret));
         if (k == 0) chk("add_retired_abs", bus1.Retired, 32'd1);
      end

      // lw to memory, reset in the second MEM stall cycle.
      bus1.Opcode = 6'b100011; bus1.Function_opcode = 6'b0;
      bus1.Alu_resultHigh = 22'h0; bus1.Mem_ready = 1'b0;
      ret0 = bus1.Retired;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      chk("rmem_state1", 32'(bus1.State),   32'd3);
      chk("rmem_mread1", 32'(bus1.MemRead), 32'd1);
      @(posedge clock);
      #1;
      chk("rmem_state2", 32'(bus1.State),   32'd3);
      reset = 1'b1;
      #1;
      chk("rmem_pcw",    32'(bus1.PCWrite),  32'd0);
      chk("rmem_rw",     32'(bus1.RegWrite), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("rmem_state_if", 32'(bus1.State),    32'd0);
      chk("rmem_rw_after", 32'(bus1.RegWrite), 32'd0);
      chk("rmem_retired",  bus1.Retired,       32'd0);
      chk("rmem_ret_kept_vs_before", 32'(ret0 != 32'd0), 32'd1);

      // 4-bit counter wrap: back-to-back j, 3 cycles each.
      @(posedge clock);
      #1;
      rst2 = 1'b0;
      repeat (45) @(posedge clock);
      #1;
      chk("wrap_state15",  32'(bus2.State),  32'd0);
      chk("wrap_ret15",    32'(bus2.Retired), 32'd15);
      repeat (3) @(posedge clock);
      #1;
      chk("wrap_ret0",     32'(bus2.Retired), 32'd0);
      repeat (3) @(posedge clock);
      #1;
      chk("wrap_ret1",     32'(bus2.Retired), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
